// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: opcode and FSM state constants shared by alu_sched,
// its arbiter and the ALU it drives.
package alu_sched_pkg;

    typedef logic [3:0] opcode_t;
    typedef logic [0:0] state_t;

    // ALU opcodes
    localparam opcode_t OP_ADD = 4'h0;
    localparam opcode_t OP_SUB = 4'h1;
    localparam opcode_t OP_AND = 4'h2;
    localparam opcode_t OP_OR  = 4'h3;
    localparam opcode_t OP_XOR = 4'h4;

    // Scheduler states
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter for alu_sched.
// Searches req starting one past 'last' and wraps at n_req.
// Optional macro ALU_SCHED_PRIO_EN: requester 0 wins whenever it requests,
// and the rest are round-robin among themselves.
module rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int n_req = 4,
    localparam int iw = $clog2(n_req)
) (
    input  logic [n_req-1:0] req,
    input  logic [iw-1:0]    last,
    output logic [n_req-1:0] grant,
    output logic [iw-1:0]    grant_idx,
    output logic             any
);

    logic [n_req-1:0] cand;
    logic [iw:0]      sum;
    logic [iw-1:0]    pos;

    // Pick the first requester after 'last' in circular order
    always_comb begin
        cand      = req;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        pos       = '0;
`ifdef ALU_SCHED_PRIO_EN
        if (req[0]) begin
            grant[0] = 1'b1;
            any      = 1'b1;
        end
        // requester 0 is excluded from the circular search; 'last' never
        // points at it because its grants do not update last_grant
        cand[0] = 1'b0;
`endif
        for (int unsigned k = 1; k <= n_req; k++) begin
            sum = {1'b0, last} + (iw+1)'(k);
            if (sum >= (iw+1)'(n_req)) begin
                sum = sum - (iw+1)'(n_req);
            end
            pos = sum[iw-1:0];
            if (!any && cand[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one clocked ALU between n_req requesters.
// Accepts one operation at a time (round-robin), holds the ALU inputs for
// alu_latency clocks, then returns R/flag to the owner with a one-cycle pulse.
// Optional macro ALU_SCHED_PRIO_EN: requester 0 has absolute priority.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int data_width  = 32,
    parameter int n_req       = 4,
    parameter int alu_latency = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [n_req-1:0]            req_valid,
    output logic [n_req-1:0]            req_ready,
    input  logic [n_req*data_width-1:0] req_A,
    input  logic [n_req*data_width-1:0] req_B,
    input  logic [n_req*4-1:0]          req_op,
    output logic [data_width-1:0]       alu_A,
    output logic [data_width-1:0]       alu_B,
    output logic [3:0]                  alu_op,
    input  logic [data_width-1:0]       alu_R,
    input  logic                        alu_flag,
    output logic [n_req-1:0]            resp_valid,
    output logic [data_width-1:0]       resp_R,
    output logic                        resp_flag,
    output logic                        busy
);

    localparam int iw = $clog2(n_req);
    localparam int cw = (alu_latency > 1) ? $clog2(alu_latency) : 1;

    state_t                  state;
    logic [iw-1:0]           last_grant;
    logic [iw-1:0]           owner;
    logic [cw-1:0]           cnt;

    logic [n_req-1:0]        grant;
    logic [iw-1:0]           grant_idx;
    logic                    any;
    logic                    accept;
    logic [data_width-1:0]   sel_A;
    logic [data_width-1:0]   sel_B;
    logic [3:0]              sel_op;
    logic [n_req-1:0]        owner_onehot;

    rr_arbiter #(
        .n_req (n_req)
    ) u_arb (
        .req       (req_valid),
        .last      (last_grant),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // Only the granted slice is ever routed towards the ALU registers
    assign sel_A  = req_A[grant_idx*data_width +: data_width];
    assign sel_B  = req_B[grant_idx*data_width +: data_width];
    assign sel_op = req_op[grant_idx*4 +: 4];

    assign accept       = (state == S_IDLE) && any;
    assign owner_onehot = n_req'(1) << owner;

    // Ready is forced low while reset is held so every output reads 0
    assign req_ready = (rst && state == S_IDLE) ? grant : '0;
    assign busy      = (state == S_EXEC);

    // FSM, arbitration pointer and latency counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= iw'(n_req - 1);
            owner      <= '0;
            cnt        <= '0;
        end else if (state == S_IDLE) begin
            if (accept) begin
                state <= S_EXEC;
                owner <= grant_idx;
                cnt   <= cw'(alu_latency - 1);
`ifdef ALU_SCHED_PRIO_EN
                if (grant_idx != '0) begin
                    last_grant <= grant_idx;
                end
`else
                last_grant <= grant_idx;
`endif
            end
        end else begin
            if (cnt == '0) begin
                state <= S_IDLE;
            end else begin
                cnt <= cnt - cw'(1);
            end
        end
    end

    // ALU operand registers: loaded on accept, held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_A  <= '0;
            alu_B  <= '0;
            alu_op <= '0;
        end else if (accept) begin
            alu_A  <= sel_A;
            alu_B  <= sel_B;
            alu_op <= sel_op;
        end
    end

    // Response capture: one-cycle valid pulse, result held until next response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= '0;
            resp_R     <= '0;
            resp_flag  <= 1'b0;
        end else begin
            resp_valid <= '0;
            if (state == S_EXEC && cnt == '0) begin
                resp_valid <= owner_onehot;
                resp_R     <= alu_R;
                resp_flag  <= alu_flag;
            end
        end
    end

endmodule
